fsm_counter_seq: RTL and testbench



---
 rtl/fsm_counter_seq_pkg.sv | 29 ++
 rtl/fsm_counter_seq_tick_gen.sv | 47 ++++
 rtl/fsm_counter_seq.sv | 138 +++++++++++++
 tb/tb_fsm_counter_seq.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/fsm_counter_seq_pkg.sv
// fsm_counter_pkg
// Shared definitions for the sequence counter and its tick generator:
//   - state_t  : FSM state encoding (IDLE, COUNTING, DONE)
//   - DIR_UP / DIR_DOWN : direction constants for the dir input
//   - clog2()  : counter-width helper, usable in parameter expressions
package fsm_counter_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COUNTING = 2'd1,
        DONE     = 2'd2
    } state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Bits needed to hold values 0..value-1 (value >= 2).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fsm_counter_seq_tick_gen.sv
// tick_gen
// Single-cycle enable generator: while en is high, counts 0..CLK_DIV-1 and
// pulses tick for the one clk in which the counter sits at CLK_DIV-1, then
// wraps to 0. While en is low the counter is held at 0, so the first tick
// after en rises arrives exactly CLK_DIV clks later.
// Ports:
//   clk  in  system clock
//   rst  in  asynchronous active-high reset
//   en   in  run enable
//   tick out one-clk pulse every CLK_DIV clks while enabled
module tick_gen
    import fsm_counter_pkg::*;
#(
    parameter int CLK_DIV = 1500000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CW = clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!en || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign tick = en && (cnt_q == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fsm_counter_seq.sv
// fsm_counter_seq
// Moore sequence counter. A rising edge on go (synchronised in) starts a run
// that counts up from 0 to CNT_MAX, or down from CNT_MAX to 0, one step per
// CLK_DIV clks. The terminal value is held in DONE for one tick period, then
// the FSM returns to IDLE. abort returns to IDLE with count cleared.
// Build option: define AUTO_REPEAT_EN to restart a run at the end of DONE
// while go is still held high (direction kept from the original start).
// Ports:
//   clk   in  system clock
//   rst   in  asynchronous active-high reset
//   go    in  start request, asynchronous to clk
//   abort in  synchronous abort (ignored in IDLE)
//   dir   in  0 = up, 1 = down; sampled only at start
//   count out current count value
//   busy  out high while COUNTING
//   done  out high while DONE
module fsm_counter_seq
    import fsm_counter_pkg::*;
#(
    parameter int CLK_DIV   = 1500000,
    parameter int CNT_WIDTH = 4,
    parameter int CNT_MAX   = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 go,
    input  logic                 abort,
    input  logic                 dir,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 busy,
    output logic                 done
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX_V = CNT_WIDTH'(CNT_MAX);

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;
    logic [CNT_WIDTH-1:0]   count_step;
    logic                   busy_q, done_q;
    logic                   dir_q, dir_d;
    logic                   sync1_q, sync2_q, prev_q;
    logic                   go_rise;
    logic                   tick;
    logic                   tick_en;

    assign go_rise = sync2_q & ~prev_q;

    // The tick counter keeps running through DONE so that DONE lasts exactly
    // one tick period; it wraps to 0 on the tick that enters DONE.
    assign tick_en = (state_q == COUNTING) || (state_q == DONE);

    tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (tick_en),
        .tick (tick)
    );

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        dir_d      = dir_q;
        count_step = (dir_q == DIR_UP) ? (count_q + CNT_WIDTH'(1))
                                       : (count_q - CNT_WIDTH'(1));
        case (state_q)
            IDLE: begin
                if (go_rise) begin
                    dir_d   = dir;
                    count_d = (dir == DIR_DOWN) ? CNT_MAX_V : '0;
                    state_d = COUNTING;
                end
            end
            COUNTING: begin
                if (abort) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (tick) begin
                    count_d = count_step;
                    // Terminal check on the new value prevents any wrap.
                    if (count_step == ((dir_q == DIR_UP) ? CNT_MAX_V : '0)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (abort) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (tick) begin
`ifdef AUTO_REPEAT_EN
                    if (sync2_q) begin
                        state_d = COUNTING;
                        count_d = (dir_q == DIR_DOWN) ? CNT_MAX_V : '0;
                    end else begin
                        state_d = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dir_q   <= DIR_UP;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            // Outputs registered from the next state so they align with state_q.
            busy_q  <= (state_d == COUNTING);
            done_q  <= (state_d == DONE);
            dir_q   <= dir_d;
            sync1_q <= go;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign count = count_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_fsm_counter_seq.sv
// tb_fsm_counter_seq
// Directed bench for fsm_counter_seq with CLK_DIV=4, CNT_WIDTH=4, CNT_MAX=5.
// A vector table drives go/abort/dir, advances a number of clocks and checks
// count/busy/done; hand-written sequences cover ignored go pulses, async
// reset and go held high (behaviour follows AUTO_REPEAT_EN).
module tb_fsm_counter_seq;

    localparam int CLK_DIV   = 4;
    localparam int CNT_WIDTH = 4;
    localparam int CNT_MAX   = 5;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 go;
    logic                 abort;
    logic                 dir;
    logic [CNT_WIDTH-1:0] count;
    logic                 busy;
    logic                 done;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string                name;
        logic                 go;
        logic                 abort;
        logic                 dir;
        int                   ncyc;
        logic [CNT_WIDTH-1:0] cnt;
        logic                 busy;
        logic                 done;
    } vec_t;

    vec_t vq[$];

    fsm_counter_seq #(
        .CLK_DIV   (CLK_DIV),
        .CNT_WIDTH (CNT_WIDTH),
        .CNT_MAX   (CNT_MAX)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .go    (go),
        .abort (abort),
        .dir   (dir),
        .count (count),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [CNT_WIDTH-1:0] ec,
                         input logic eb, input logic ed);
        n_tests++;
        if (count !== ec || busy !== eb || done !== ed) begin
            n_fail++;
            $display("FAIL %s: got count=%0d busy=%0b done=%0b, want count=%0d busy=%0b done=%0b",
                     name, count, busy, done, ec, eb, ed);
        end else begin
            $display("[TB] %s: count=%0d busy=%0b done=%0b ok", name, count, busy, done);
        end
    endtask

    function automatic void add(input string nm, input logic g, input logic a,
                                input logic d, input int n,
                                input logic [CNT_WIDTH-1:0] c,
                                input logic b, input logic dn);
        vec_t v;
        v.name = nm; v.go = g; v.abort = a; v.dir = d; v.ncyc = n;
        v.cnt = c; v.busy = b; v.done = dn;
        vq.push_back(v);
    endfunction

    initial begin
        // Up run: COUNTING 3 clks after go, one step every 4 clks, DONE 4 clks.
        add("up_sync1",      1, 0, 0, 1, 0, 0, 0);
        add("up_sync2",      0, 0, 0, 1, 0, 0, 0);
        add("up_start",      0, 0, 0, 1, 0, 1, 0);
        add("up_pre_step1",  0, 0, 0, 3, 0, 1, 0);
        add("up_step1",      0, 0, 0, 1, 1, 1, 0);
        add("up_step2",      0, 0, 0, 4, 2, 1, 0);
        add("up_step3",      0, 0, 0, 4, 3, 1, 0);
        add("up_step4",      0, 0, 0, 4, 4, 1, 0);
        add("up_pre_term",   0, 0, 0, 3, 4, 1, 0);
        add("up_done",       0, 0, 0, 1, 5, 0, 1);
        add("up_done_hold",  0, 0, 0, 3, 5, 0, 1);
        add("up_idle",       0, 0, 0, 1, 5, 0, 0);
        // Down run; abort coincident with the start is ignored, dir is latched.
        add("dn_sync1",      1, 0, 1, 1, 5, 0, 0);
        add("dn_sync2",      0, 0, 1, 1, 5, 0, 0);
        add("dn_start_abort",0, 1, 1, 1, 5, 1, 0);
        add("dn_step1",      0, 0, 0, 4, 4, 1, 0);
        add("dn_step2",      0, 0, 0, 4, 3, 1, 0);
        add("dn_step3",      0, 0, 0, 4, 2, 1, 0);
        add("dn_step4",      0, 0, 0, 4, 1, 1, 0);
        add("dn_done",       0, 0, 0, 4, 0, 0, 1);
        add("dn_idle",       0, 0, 0, 4, 0, 0, 0);
        // Abort at count=2 between ticks.
        add("ab_sync1",      1, 0, 0, 1, 0, 0, 0);
        add("ab_sync2",      0, 0, 0, 1, 0, 0, 0);
        add("ab_start",      0, 0, 0, 1, 0, 1, 0);
        add("ab_to2",        0, 0, 0, 8, 2, 1, 0);
        add("ab_abort",      0, 1, 0, 1, 0, 0, 0);
        add("ab_idle",       0, 0, 0, 4, 0, 0, 0);
        // Abort on the same edge as a tick: count clears instead of reaching 3.
        add("ab2_sync1",     1, 0, 0, 1, 0, 0, 0);
        add("ab2_sync2",     0, 0, 0, 1, 0, 0, 0);
        add("ab2_start",     0, 0, 0, 1, 0, 1, 0);
        add("ab2_to2",       0, 0, 0, 8, 2, 1, 0);
        add("ab2_pre_tick",  0, 0, 0, 3, 2, 1, 0);
        add("ab2_abort_tick",0, 1, 0, 1, 0, 0, 0);
        add("ab2_idle",      0, 0, 0, 4, 0, 0, 0);

        rst = 1'b0; go = 1'b0; abort = 1'b0; dir = 1'b0;
        #1 rst = 1'b1;
        #1 check("reset", 0, 0, 0);
        step(2);
        rst = 1'b0;
        step(2);
        check("post_reset_idle", 0, 0, 0);

        foreach (vq[i]) begin
            go    = vq[i].go;
            abort = vq[i].abort;
            dir   = vq[i].dir;
            step(vq[i].ncyc);
            check(vq[i].name, vq[i].cnt, vq[i].busy, vq[i].done);
        end
        go = 1'b0; abort = 1'b0; dir = 1'b0;

        // go pulses mid-COUNTING and during DONE are ignored, not queued.
        go = 1'b1; step(1); go = 1'b0; step(2);
        check("ig_start", 0, 1, 0);
        step(5);
        go = 1'b1; step(1); go = 1'b0; step(14);
        check("ig_done", 5, 0, 1);
        step(1);
        go = 1'b1; step(1); go = 1'b0; step(2);
        check("ig_idle", 5, 0, 0);
        step(6);
        check("ig_no_queue", 5, 0, 0);
        go = 1'b1; step(1); go = 1'b0; step(2);
        check("ig_restart", 0, 1, 0);

        // Asynchronous reset between clock edges mid-count.
        step(5);
        check("rst_pre", 1, 1, 0);
        #2 rst = 1'b1;
        #1 check("rst_async", 0, 0, 0);
        step(2);
        rst = 1'b0;
        step(10);
        check("rst_no_start", 0, 0, 0);

        // go held high through a complete run.
        go = 1'b1; step(3);
        check("hold_start", 0, 1, 0);
        step(20);
        check("hold_done", 5, 0, 1);
        step(4);
`ifdef AUTO_REPEAT_EN
        check("hold_repeat", 0, 1, 0);
        step(20);
        check("hold_done2", 5, 0, 1);
        go = 1'b0;
        step(4);
        check("hold_release", 5, 0, 0);
`else
        check("hold_single", 5, 0, 0);
        step(8);
        check("hold_stay", 5, 0, 0);
`endif
        go = 1'b0;
        step(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
